// File: rtl/cache_fill_arbiter_pkg.sv
// +----------------------------------------------------------------------------+
// | cache_fill_arbiter_pkg : shared encodings for the cache fill arbiter        |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

package cache_fill_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_FILL  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  // Byte-offset bits within a block of 16-bit words.
  function automatic int blk_offset_bits(input int blk_words);
    return $clog2(blk_words * 2);
  endfunction

  localparam int BLK_OFFSET_BITS = blk_offset_bits(8);

endpackage

`default_nettype wire

// File: rtl/cache_fill_arbiter_fill_counter.sv
// +----------------------------------------------------------------------------+
// | cache_fill_arbiter_fill_counter : clearable up-counter with a last flag     |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module cache_fill_arbiter_fill_counter #(
  parameter int CNT_W    = 4,
  parameter int LAST_VAL = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o,
  output logic             last_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign last_o  = (count_q == CNT_W'(LAST_VAL));

endmodule

`default_nettype wire

// File: rtl/cache_fill_arbiter.sv
// +----------------------------------------------------------------------------+
// | cache_fill_arbiter : shares the memory port between I/D refills and stores  |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module cache_fill_arbiter
  import cache_fill_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int BLK_WORDS = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_miss,
  input  logic [ADDR_W-1:0]            i_miss_addr,
  input  logic                         d_miss,
  input  logic [ADDR_W-1:0]            d_miss_addr,
  input  logic                         d_wr_req,
  input  logic [ADDR_W-1:0]            d_wr_addr,
  input  logic [DATA_W-1:0]            d_wr_data,
  output logic                         mem_en,
  output logic                         mem_wr,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W-1:0]            mem_rdata,
  input  logic                         mem_rvalid,
  output logic [DATA_W-1:0]            fill_data,
  output logic [$clog2(BLK_WORDS)-1:0] fill_idx,
  output logic                         i_fill_we,
  output logic                         d_fill_we,
  output logic                         i_fill_done,
  output logic                         d_fill_done,
  output logic                         d_wr_ack,
  output logic                         i_stall,
  output logic                         d_stall
);

  localparam int IDX_W = $clog2(BLK_WORDS);
  localparam int CNT_W = IDX_W + 1;
  localparam int OFF_W = blk_offset_bits(BLK_WORDS);
  localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'((1 << OFF_W) - 1);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] base_q,  base_d;

  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  rcv_cnt;
  logic              issue_all;
  logic              rcv_last;
  logic              cnt_clr;
  logic              issue_go;
  logic              rcv_go;
  logic              wr_go;

  assign cnt_clr  = (state_q == ST_IDLE);
  assign wr_go    = (state_q == ST_WRITE);
  assign issue_go = (state_q == ST_FILL) && !issue_all;
  // Pulses beyond a full block are dropped rather than wrapping the index.
  assign rcv_go   = (state_q == ST_FILL) && mem_rvalid && !rcv_cnt[IDX_W];

  cache_fill_arbiter_fill_counter #(
    .CNT_W    (CNT_W),
    .LAST_VAL (BLK_WORDS)
  ) u_issue_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (cnt_clr),
    .inc_i   (issue_go),
    .count_o (issue_cnt),
    .last_o  (issue_all)
  );

  cache_fill_arbiter_fill_counter #(
    .CNT_W    (CNT_W),
    .LAST_VAL (BLK_WORDS - 1)
  ) u_rcv_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (cnt_clr),
    .inc_i   (rcv_go),
    .count_o (rcv_cnt),
    .last_o  (rcv_last)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    base_d  = base_q;
    case (state_q)
      ST_IDLE: begin
        if (d_wr_req) begin
          state_d = ST_WRITE;
        end else if (d_miss) begin
          state_d = ST_FILL;
          owner_d = OWNER_D;
          base_d  = d_miss_addr & BASE_MASK;
        end else if (i_miss) begin
          state_d = ST_FILL;
          owner_d = OWNER_I;
          base_d  = i_miss_addr & BASE_MASK;
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_FILL:  if (rcv_go && rcv_last) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWNER_I;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      base_q  <= base_d;
    end
  end

  always_comb begin
    mem_en      = wr_go | issue_go;
    mem_wr      = wr_go;
    mem_addr    = '0;
    mem_wdata   = '0;
    if (wr_go) begin
      mem_addr  = d_wr_addr;
      mem_wdata = d_wr_data;
    end else if (issue_go) begin
      mem_addr  = base_q + ADDR_W'({issue_cnt, 1'b0});
    end
    fill_data   = rcv_go ? mem_rdata : '0;
    fill_idx    = rcv_go ? rcv_cnt[IDX_W-1:0] : '0;
    i_fill_we   = rcv_go && (owner_q == OWNER_I);
    d_fill_we   = rcv_go && (owner_q == OWNER_D);
    i_fill_done = (state_q == ST_DONE) && (owner_q == OWNER_I);
    d_fill_done = (state_q == ST_DONE) && (owner_q == OWNER_D);
    d_wr_ack    = wr_go;
    i_stall     = i_miss & ~i_fill_done;
    d_stall     = (d_miss & ~d_fill_done) | (d_wr_req & ~d_wr_ack);
  end

endmodule

`default_nettype wire

// File: tb/tb_cache_fill_arbiter.sv
// Scoreboard bench for cache_fill_arbiter with a fixed-latency (L=4) memory model.
`default_nettype none

module tb_cache_fill_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int BLK    = 8;
  localparam int LAT    = 4;
  localparam logic [15:0] RD_XOR = 16'h5A5A;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_miss, d_miss, d_wr_req;
  logic [ADDR_W-1:0] i_miss_addr, d_miss_addr, d_wr_addr;
  logic [DATA_W-1:0] d_wr_data;
  logic              mem_en, mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_rvalid;
  logic [DATA_W-1:0] fill_data;
  logic [2:0]        fill_idx;
  logic              i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_ack;
  logic              i_stall, d_stall;
  logic              inj_rv;

  always #5 clk = ~clk;

  cache_fill_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BLK_WORDS(BLK)) dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .fill_data(fill_data), .fill_idx(fill_idx),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
    .d_wr_ack(d_wr_ack), .i_stall(i_stall), .d_stall(d_stall)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: a read issued in cycle k returns in cycle k+LAT with data addr^RD_XOR.
  logic [LAT-1:0]    pv = '0;
  logic [ADDR_W-1:0] pa [LAT];
  always @(posedge clk) begin
    pv    <= {pv[LAT-2:0], mem_en & ~mem_wr};
    pa[0] <= mem_addr;
    for (int i = 1; i < LAT; i++) pa[i] <= pa[i-1];
  end
  assign mem_rvalid = pv[LAT-1] | inj_rv;
  assign mem_rdata  = pv[LAT-1] ? (pa[LAT-1] ^ RD_XOR) : 16'h0;

  typedef struct packed { logic wr; logic [15:0] addr; logic [15:0] wdata; } mem_t;
  typedef struct packed { logic own_d; logic [2:0] idx; logic [15:0] data; } fill_t;
  typedef struct packed { logic own_d; int cyc; } done_t;

  mem_t  mem_q [$];
  fill_t fill_q[$];
  done_t done_q[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: got an event, expected none", name);
  endtask

  task automatic push_block(input logic own_d, input logic [15:0] base, input int dcyc);
    for (int i = 0; i < BLK; i++) begin
      mem_q.push_back('{wr: 1'b0, addr: base + 16'(2*i), wdata: 16'h0});
      fill_q.push_back('{own_d: own_d, idx: 3'(i), data: (base + 16'(2*i)) ^ RD_XOR});
    end
    done_q.push_back('{own_d: own_d, cyc: dcyc});
  endtask

  // Monitor: pops and compares whenever the DUT presents an event.
  mem_t  me;
  fill_t fe;
  done_t de;
  always @(negedge clk) begin
    if (mem_en) begin
      if (mem_q.size() == 0) unexpected("mem_issue");
      else begin
        me = mem_q.pop_front();
        chk("mem_issue", {mem_wr, mem_addr, mem_wdata, d_wr_ack}, {me.wr, me.addr, me.wdata, me.wr});
      end
    end else if (d_wr_ack || mem_wdata != 16'h0 || mem_wr) begin
      chk("mem_idle", {mem_wr, d_wr_ack, mem_wdata}, 64'h0);
    end
    if (i_fill_we || d_fill_we) begin
      if (fill_q.size() == 0) unexpected("fill_we");
      else begin
        fe = fill_q.pop_front();
        chk("fill", {i_fill_we, d_fill_we, fill_idx, fill_data}, {~fe.own_d, fe.own_d, fe.idx, fe.data});
      end
    end
    if (i_fill_done || d_fill_done) begin
      if (done_q.size() == 0) unexpected("fill_done");
      else begin
        de = done_q.pop_front();
        chk("fill_done", {i_fill_done, d_fill_done}, {~de.own_d, de.own_d});
        if (de.cyc >= 0) chk("done_latency", 64'(cyc), 64'(de.cyc));
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // which: 0 i_fill_done, 1 d_fill_done, 2 d_wr_ack; watch: 1 i_stall high, 2 d_stall high
  task automatic wait_for(input int which, input int max, input int watch, input string name);
    int  n    = 0;
    bit  seen = 0;
    bit  ok   = 1;
    while (!seen && n < max) begin
      @(negedge clk);
      case (which)
        0:       seen = i_fill_done;
        1:       seen = d_fill_done;
        default: seen = d_wr_ack;
      endcase
      if (!seen && watch == 1 && !i_stall) ok = 0;
      if (!seen && watch == 2 && !d_stall) ok = 0;
      n++;
    end
    chk({name, "_seen"}, 64'(seen), 64'd1);
    if (watch != 0) chk({name, "_stall_held"}, 64'(ok), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; inj_rv = 1'b0;
    i_miss = 1'b0; d_miss = 1'b0; d_wr_req = 1'b0;
    i_miss_addr = '0; d_miss_addr = '0; d_wr_addr = '0; d_wr_data = '0;
    repeat (3) next();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mem",   {mem_en, mem_wr, mem_addr, mem_wdata}, 64'h0);
    chk("rst_fill",  {fill_data, fill_idx, i_fill_we, d_fill_we}, 64'h0);
    chk("rst_flags", {i_fill_done, d_fill_done, d_wr_ack, i_stall, d_stall}, 64'h0);
    next();

    // 1: single I miss, latency 13 to done
    push_block(1'b0, 16'h1230, cyc + 13);
    i_miss = 1'b1; i_miss_addr = 16'h1234;
    @(negedge clk);
    chk("t1_stall_req", 64'(i_stall), 64'd1);
    wait_for(0, 40, 1, "t1_done");
    chk("t1_stall_drop", 64'(i_stall), 64'd0);
    next(); i_miss = 1'b0;
    repeat (2) next();

    // 2: simultaneous misses, D first
    push_block(1'b1, 16'h8000, -1);
    push_block(1'b0, 16'h0040, -1);
    i_miss = 1'b1; i_miss_addr = 16'h0040;
    d_miss = 1'b1; d_miss_addr = 16'h8008;
    wait_for(1, 40, 1, "t2_d_done");
    chk("t2_istall_at_ddone", 64'(i_stall), 64'd1);
    next(); d_miss = 1'b0;
    wait_for(0, 40, 1, "t2_i_done");
    next(); i_miss = 1'b0;
    repeat (2) next();

    // 3: store arrives during an I fill
    push_block(1'b0, 16'h1000, -1);
    mem_q.push_back('{wr: 1'b1, addr: 16'h2000, wdata: 16'hBEEF});
    i_miss = 1'b1; i_miss_addr = 16'h100A;
    repeat (4) next();
    d_wr_req = 1'b1; d_wr_addr = 16'h2000; d_wr_data = 16'hBEEF;
    wait_for(0, 40, 2, "t3_i_done");
    next(); i_miss = 1'b0;
    wait_for(2, 10, 2, "t3_ack");
    next(); d_wr_req = 1'b0;
    repeat (2) next();

    // 4: store and D miss together, store first
    mem_q.push_back('{wr: 1'b1, addr: 16'h3000, wdata: 16'h1234});
    push_block(1'b1, 16'h4000, -1);
    d_wr_req = 1'b1; d_wr_addr = 16'h3000; d_wr_data = 16'h1234;
    d_miss = 1'b1; d_miss_addr = 16'h400E;
    wait_for(2, 10, 2, "t4_ack");
    next(); d_wr_req = 1'b0;
    wait_for(1, 40, 2, "t4_d_done");
    next(); d_miss = 1'b0;
    repeat (2) next();

    // 5: reset at the third issued read, then late rvalid pulses
    for (int i = 0; i < 3; i++) mem_q.push_back('{wr: 1'b0, addr: 16'h5000 + 16'(2*i), wdata: 16'h0});
    i_miss = 1'b1; i_miss_addr = 16'h5000;
    begin
      int n = 0;
      while (!(mem_en && mem_addr == 16'h5004) && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("t5_third_read_seen", 64'(mem_en && mem_addr == 16'h5004), 64'd1);
    end
    rst = 1'b1; i_miss = 1'b0;
    next();
    next(); rst = 1'b0;
    begin
      bit quiet = 1;
      for (int i = 0; i < 14; i++) begin
        inj_rv = (i >= 4 && i < 14 && i[0] == 1'b0) ? 1'b1 : 1'b0;
        @(negedge clk);
        if (mem_en || mem_wr || mem_addr != 0 || mem_wdata != 0 || fill_data != 0 || fill_idx != 0 ||
            i_fill_we || d_fill_we || i_fill_done || d_fill_done || d_wr_ack || i_stall || d_stall)
          quiet = 0;
        next();
      end
      inj_rv = 1'b0;
      chk("t5_quiet_after_rst", 64'(quiet), 64'd1);
    end
    chk("t5_reads_consumed", 64'(mem_q.size()), 64'd0);
    push_block(1'b0, 16'h5000, -1);
    i_miss = 1'b1; i_miss_addr = 16'h5000;
    wait_for(0, 40, 1, "t5_refill_done");
    next(); i_miss = 1'b0;
    repeat (2) next();

    // 6: requester drops its miss mid-fill
    push_block(1'b0, 16'h6000, -1);
    i_miss = 1'b1; i_miss_addr = 16'h6006;
    begin
      int fills = 0;
      int n = 0;
      while (fills < 3 && n < 30) begin
        @(negedge clk);
        if (i_fill_we) fills++;
        n++;
      end
      chk("t6_three_fills", 64'(fills), 64'd3);
    end
    next(); i_miss = 1'b0;
    wait_for(0, 40, 0, "t6_done");
    next();
    @(negedge clk);
    chk("t6_idle", {mem_en, i_fill_we, i_fill_done, i_stall}, 64'h0);

    repeat (8) next();
    chk("end_mem_q",  64'(mem_q.size()),  64'd0);
    chk("end_fill_q", 64'(fill_q.size()), 64'd0);
    chk("end_done_q", 64'(done_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
